// File: rtl/rd_line_sched_if.sv
// rd_line_sched_if: pixel-domain fetch handshake between the line scheduler (master)
// and the memclk line-read engine (slave). The *_async signals originate in memclk.
interface rd_line_sched_if #(
  parameter int unsigned LINE_W = 11
);
  logic              req;
  logic [LINE_W-1:0] line_addr;
  logic              frame_sel;
  logic              done_async;
  logic              buf_ready_async;

  modport master (
    output req, line_addr, frame_sel,
    input  done_async, buf_ready_async
  );

  modport slave (
    input  req, line_addr, frame_sel,
    output done_async, buf_ready_async
  );
endinterface

// File: rtl/rd_line_sched.sv
// rd_line_sched: pixel-clock scheduler that requests one DDR line fetch per displayed line
// over a 4-phase req/done handshake, selects the front buffer and flags display underrun.
// Optional feature macro: UNDERRUN_CNT_EN builds a saturating underrun counter.
module rd_line_sched #(
  parameter int unsigned LINE_W   = 11,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned UCNT_W   = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              vs,
  input  logic              de,
  rd_line_sched_if.master   rd,
  output logic              frame_start,
  output logic              busy,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  logic [1:0]          state, state_n;
  logic [SYNC_STG-1:0] done_sync, rdy_sync;
  logic                done_s, buf_ready_s;
  logic                vs_d, de_d;
  logic                vs_rise, de_rise, de_fall, active;
  logic                frame_pend, frame_pend_n;
  logic                nxt, nxt_n;
  logic                sel_pend, sel_pend_n;
  logic                req_n, sel_n, underrun_n, fire_line;
  logic [LINE_W-1:0]   line_n, depth, last_line;

  // Cross memclk levels into pclk and keep one-cycle history of vs/de for edge detection
  always_ff @(posedge pclk) begin
    if (rst) begin
      done_sync <= '0;
      rdy_sync  <= '0;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
    end else begin
      done_sync <= {done_sync[SYNC_STG-2:0], rd.done_async};
      rdy_sync  <= {rdy_sync[SYNC_STG-2:0], rd.buf_ready_async};
      vs_d      <= vs;
      de_d      <= de;
    end
  end

  assign done_s      = done_sync[SYNC_STG-1];
  assign buf_ready_s = rdy_sync[SYNC_STG-1];
  assign vs_rise     = vs & ~vs_d;
  assign de_rise     = de & ~de_d;
  assign de_fall     = ~de & de_d;
  assign active      = (mode != MODE_OFF);

  // Lines per frame for the current video mode
  always_comb begin
    depth = LINE_W'(900);
    case (mode)
      2'd0:    depth = LINE_W'(900);
      2'd1:    depth = LINE_W'(768);
      2'd2:    depth = LINE_W'(1080);
      default: depth = LINE_W'(900);
    endcase
    last_line = depth - LINE_W'(1);
  end

  // Next-state and output decode; swaps and line changes happen only in IDLE
  always_comb begin
    state_n      = state;
    req_n        = rd.req;
    line_n       = rd.line_addr;
    sel_n        = rd.frame_sel;
    frame_pend_n = frame_pend;
    nxt_n        = nxt;
    sel_pend_n   = sel_pend;
    underrun_n   = 1'b0;
    fire_line    = active && de_fall && (rd.line_addr < last_line);

    if (active && ((de_rise && ((state != IDLE) || nxt)) || (de_fall && nxt)))
      underrun_n = 1'b1;
    if (fire_line)
      nxt_n = 1'b1;

    if ((state == IDLE) && (sel_pend || (vs_rise && buf_ready_s))) begin
      sel_n      = ~rd.frame_sel;
      sel_pend_n = 1'b0;
    end else if (vs_rise && buf_ready_s) begin
      sel_pend_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (active) begin
          if (frame_pend) begin
            line_n       = '0;
            frame_pend_n = 1'b0;
            nxt_n        = 1'b0;
            state_n      = REQ;
          end else if (nxt || fire_line) begin
            line_n  = rd.line_addr + LINE_W'(1);
            nxt_n   = 1'b0;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        req_n   = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_s) begin
          req_n   = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!done_s)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (vs_rise)
      frame_pend_n = 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      rd.req       <= 1'b0;
      rd.line_addr <= '0;
      rd.frame_sel <= 1'b0;
      frame_pend   <= 1'b0;
      nxt          <= 1'b0;
      sel_pend     <= 1'b0;
      frame_start  <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_n;
      rd.req       <= req_n;
      rd.line_addr <= line_n;
      rd.frame_sel <= sel_n;
      frame_pend   <= frame_pend_n;
      nxt          <= nxt_n;
      sel_pend     <= sel_pend_n;
      frame_start  <= vs_rise;
      busy         <= (state_n != IDLE);
      underrun     <= underrun_n;
    end
  end

`ifdef UNDERRUN_CNT_EN
  // Saturating count of underrun pulses, cleared only by reset
  always_ff @(posedge pclk) begin
    if (rst)
      underrun_cnt <= '0;
    else if (underrun_n && (underrun_cnt != {UCNT_W{1'b1}}))
      underrun_cnt <= underrun_cnt + UCNT_W'(1);
  end
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_line_sched.sv
// tb_rd_line_sched: directed bench for rd_line_sched with a frame-level request model,
// a memclk-style done responder and a per-cycle compare process.
module tb_rd_line_sched;
  localparam int unsigned LINE_W = 11;
  localparam int unsigned UCNT_W = 16;

  logic              pclk = 1'b0;
  logic              rst  = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic              vs   = 1'b0;
  logic              de   = 1'b0;
  logic              frame_start, busy, underrun;
  logic [UCNT_W-1:0] underrun_cnt;

  rd_line_sched_if #(.LINE_W(LINE_W)) rif ();

  rd_line_sched #(.LINE_W(LINE_W), .SYNC_STG(2), .UCNT_W(UCNT_W)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .mode         (mode),
    .vs           (vs),
    .de           (de),
    .rd           (rif),
    .frame_start  (frame_start),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct { int line; int sel; } exp_t;
  exp_t exp_q[$];

  int checks = 0, passes = 0;
  int req_rises = 0, ur_pulses = 0, last_req_line = -1;
  int resp_delay = 10;
  int m_sel = 0, m_line = 0, m_mode = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  function automatic int depth_of(input int md);
    case (md)
      0: return 900;
      1: return 768;
      2: return 1080;
      default: return 0;
    endcase
  endfunction

  task automatic push_exp(input int line);
    exp_t e;
    e.line = line;
    e.sel  = m_sel;
    exp_q.push_back(e);
  endtask

  // Frame start: optional buffer swap, then line 0 is the next fetch
  task automatic model_vs(input int md, input bit brdy);
    m_mode = md;
    if (brdy) m_sel = 1 - m_sel;
    m_line = 0;
    if (md != 3) push_exp(0);
  endtask

  // End of a displayed line: fetch the following line if one exists
  task automatic model_defall();
    if (m_mode != 3 && m_line < depth_of(m_mode) - 1) begin
      m_line++;
      push_exp(m_line);
    end
  endtask

  task automatic vs_pulse(input int md, input bit brdy, input int pre);
    rif.buf_ready_async = brdy;
    step(pre);
    vs   = 1'b1;
    mode = 2'(md);
    model_vs(md, brdy);
    step(4);
    vs = 1'b0;
    step(50);
  endtask

  task automatic lines(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      step(h);
      de = 1'b0;
      model_defall();
      step(l);
    end
  endtask

  // Reader side: raise done resp_delay cycles after req, drop it once req falls
  initial begin
    int cnt;
    cnt = 0;
    rif.done_async      = 1'b0;
    rif.buf_ready_async = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (rst) begin
        rif.done_async = 1'b0;
        cnt = 0;
      end else if (rif.req && !rif.done_async) begin
        if (cnt >= resp_delay) rif.done_async = 1'b1;
        else cnt++;
      end else if (!rif.req && rif.done_async) begin
        rif.done_async = 1'b0;
        cnt = 0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    bit   req_q, ur_q, vs_h1, vs_h2;
    int   hold_line, hold_sel;
    exp_t e;
    req_q = 0; ur_q = 0; vs_h1 = 0; vs_h2 = 0; hold_line = 0; hold_sel = 0;
    forever begin
      @(negedge pclk);
      if (rst) begin
        req_q = 0;
        ur_q  = 0;
      end else begin
        chk("frame_start", int'(frame_start), int'(vs_h1 && !vs_h2));
        if (rif.req && !req_q) begin
          req_rises++;
          last_req_line = int'(rif.line_addr);
          if (exp_q.size() == 0) begin
            chk("unexpected_req", int'(rif.line_addr), -1);
          end else begin
            e = exp_q.pop_front();
            chk("req_line", int'(rif.line_addr), e.line);
            chk("req_sel", int'(rif.frame_sel), e.sel);
          end
          hold_line = int'(rif.line_addr);
          hold_sel  = int'(rif.frame_sel);
        end else if (rif.req) begin
          chk("line_stable", int'(rif.line_addr), hold_line);
          chk("sel_stable", int'(rif.frame_sel), hold_sel);
        end
        if (rif.req) chk("busy_during_req", int'(busy), 1);
        if (underrun) begin
          ur_pulses++;
          chk("underrun_width", int'(ur_q), 0);
        end
        req_q = rif.req;
        ur_q  = underrun;
      end
      vs_h2 = vs_h1;
      vs_h1 = vs;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, u0;
    // Power-on reset values
    step(3);
    chk("rst_req", int'(rif.req), 0);
    chk("rst_line", int'(rif.line_addr), 0);
    chk("rst_sel", int'(rif.frame_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_ucnt", int'(underrun_cnt), 0);
    rst = 1'b0;
    step(2);

    // Buffer swap at frame start follows buf_ready
    vs_pulse(1, 1'b1, 5);
    chk("sel_after_ready", int'(rif.frame_sel), 1);
    lines(3, 6, 26);
    vs_pulse(1, 1'b0, 5);
    chk("sel_no_ready", int'(rif.frame_sel), 1);
    lines(3, 6, 26);

    // Reset while a fetch is in flight
    de = 1'b1;
    step(6);
    de = 1'b0;
    model_defall();
    step(5);
    chk("t1_req_before_rst", int'(rif.req), 1);
    rst = 1'b1;
    exp_q.delete();
    m_sel = 0;
    m_line = 0;
    step(3);
    chk("t1_req", int'(rif.req), 0);
    chk("t1_line", int'(rif.line_addr), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_sel", int'(rif.frame_sel), 0);
    rst = 1'b0;
    step(5);

    // Slow reader: done arrives after the next line's de rise on five lines
    vs_pulse(1, 1'b0, 5);
    u0 = ur_pulses;
    resp_delay = 60;
    lines(6, 20, 60);
    step(40);
    resp_delay = 10;
    chk("t4_underruns", ur_pulses - u0, 5);
`ifdef UNDERRUN_CNT_EN
    chk("t4_ucnt", int'(underrun_cnt), 5);
`else
    chk("t4_ucnt", int'(underrun_cnt), 0);
`endif
    chk("t4_busy_idle", int'(busy), 0);

    // Full HMD frame: exactly 900 fetches, none after the last line
    r0 = req_rises;
    vs_pulse(0, 1'b0, 5);
    lines(900, 6, 26);
    step(30);
    chk("t2_req_count", req_rises - r0, 900);
    chk("t2_last_line", last_req_line, 899);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Frame start while line 500 fetch is awaiting done
    vs_pulse(0, 1'b0, 5);
    lines(499, 6, 26);
    de = 1'b1;
    step(6);
    de = 1'b0;
    model_defall();
    step(5);
    chk("t5_req_inflight", int'(rif.req), 1);
    chk("t5_line_500", int'(rif.line_addr), 500);
    r0 = req_rises;
    vs_pulse(0, 1'b0, 4);
    chk("t5_restart_line", last_req_line, 0);
    chk("t5_restart_count", req_rises - r0, 1);
    lines(3, 6, 26);
    step(30);
    chk("t5_after_lines", last_req_line, 3);

    // Disabled mode: full timing, no fetches, no underruns
    r0 = req_rises;
    u0 = ur_pulses;
    vs_pulse(3, 1'b0, 5);
    lines(300, 6, 26);
    vs_pulse(3, 1'b0, 5);
    lines(300, 6, 26);
    chk("t6_no_req", req_rises - r0, 0);
    chk("t6_no_underrun", ur_pulses - u0, 0);
    chk("t6_busy", int'(busy), 0);

    chk("total_underruns", ur_pulses, 5);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
